// File: rtl/gpio_uart_tx.sv
// GPIO-to-UART bridge: write strobes from the memory controller are queued in a
// FIFO and serialized as 8N1 frames on a registered tx pin.
module gpio_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    gpio_data,
    input  logic                          gpio_en,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [7:0]      shift;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr, wr_next, rd_next, level_next;
    logic [7:0]      head;
    logic            push, pop, baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign head      = mem[rd_ptr[AW-1:0]];

    // The FSM takes the head byte when idle, or at the last stop-bit cycle so
    // queued bytes go out back-to-back.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty)
            pop = (state == IDLE) || ((state == STOP) && baud_last);
    end

    assign push       = gpio_en && (!fifo_full || pop);
    assign wr_next    = push ? wr_ptr + PTR_ONE : wr_ptr;
    assign rd_next    = pop  ? rd_ptr + PTR_ONE : rd_ptr;
    assign level_next = wr_next - rd_next;
    assign busy       = (state != IDLE) || !fifo_empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            wr_ptr     <= wr_next;
            rd_ptr     <= rd_next;
            level      <= level_next;
            fifo_full  <= (level_next == LVL_FULL);
            fifo_empty <= (level_next == '0);
            if (gpio_en && fifo_full && !pop)
                overflow <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; pointers alone define which
    // entries are valid, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= gpio_data;
    end

    // tx is registered from the current state, so it trails the state by one
    // cycle uniformly and no input reaches the pin combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shift    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shift <= head;
                        state <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    tx <= shift[0];
                    if (baud_last) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7)
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= head;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Directed bench for gpio_uart_tx: a fast-baud shallow-FIFO instance for timing
// and FIFO corner cases, and a second instance fed a random byte stream.
module tb_gpio_uart_tx;

    localparam int CPB_A = 4;
    localparam int DEP_A = 4;
    localparam int CPB_B = 2;
    localparam int DEP_B = 16;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 0 = first bit on the line (start)
    } vec_t;

    typedef struct {
        logic [9:0] frame;
        int         start;
    } rx_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    int         cyc = 0;

    logic [7:0] gpio_data_a = '0, gpio_data_b = '0;
    logic       gpio_en_a = 1'b0, gpio_en_b = 1'b0;
    logic       tx_a, busy_a, fifo_full_a, fifo_empty_a, overflow_a;
    logic       tx_b, busy_b, fifo_full_b, fifo_empty_b, overflow_b;
    logic [2:0] level_a;
    logic [4:0] level_b;

    rx_t        rxq_a[$];
    rx_t        rxq_b[$];
    logic [7:0] exp_b[$];

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [2:0] max_level_a = '0;
    logic       clr_max = 1'b0;

    gpio_uart_tx #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(DEP_A)) dut_a (
        .clk(clk), .rst(rst), .gpio_data(gpio_data_a), .gpio_en(gpio_en_a),
        .tx(tx_a), .busy(busy_a), .fifo_full(fifo_full_a), .fifo_empty(fifo_empty_a),
        .overflow(overflow_a), .level(level_a)
    );

    gpio_uart_tx #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEP_B)) dut_b (
        .clk(clk), .rst(rst), .gpio_data(gpio_data_b), .gpio_en(gpio_en_b),
        .tx(tx_b), .busy(busy_b), .fifo_full(fifo_full_b), .fifo_empty(fifo_empty_b),
        .overflow(overflow_b), .level(level_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (clr_max)
            max_level_a <= '0;
        else if (level_a > max_level_a)
            max_level_a <= level_a;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic line(input int which);
        return (which == 0) ? tx_a : tx_b;
    endfunction

    // Receiver model: detects a low line on a falling clock edge, samples each
    // bit mid-cell, and records the frame with the cycle the start bit appeared.
    task automatic uart_rx(input int which);
        int  cpb;
        rx_t r;
        cpb = (which == 0) ? CPB_A : CPB_B;
        forever begin
            @(negedge clk);
            if (rst && line(which) == 1'b0) begin
                r.start = cyc;
                repeat (cpb / 2) @(negedge clk);
                r.frame[0] = line(which);
                for (int k = 1; k < 10; k++) begin
                    repeat (cpb) @(negedge clk);
                    r.frame[k] = line(which);
                end
                repeat (cpb - cpb / 2 - 1) @(negedge clk);
                if (which == 0) rxq_a.push_back(r);
                else            rxq_b.push_back(r);
            end
        end
    endtask

    initial uart_rx(0);
    initial uart_rx(1);

    task automatic push_a(input logic [7:0] b, output int e0);
        gpio_data_a = b;
        gpio_en_a   = 1'b1;
        @(negedge clk);
        gpio_en_a   = 1'b0;
        e0 = cyc;
    endtask

    task automatic get_frame_a(output rx_t r, output bit ok);
        int t = 0;
        while (rxq_a.size() == 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        ok = (rxq_a.size() != 0);
        if (ok) r = rxq_a.pop_front();
        else begin
            r.frame = '0;
            r.start = 0;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        rx_t  r;
        bit   ok;
        int   e0, e1, t, sent;
        int   starts[3];

        vecs[0] = '{8'hA5, 10'h34A};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'h5A, 10'h2B4};
        vecs[4] = '{8'h01, 10'h202};
        vecs[5] = '{8'h80, 10'h300};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset tx", tx_a, 1);
        check("reset busy", busy_a, 0);
        check("reset full", fifo_full_a, 0);
        check("reset empty", fifo_empty_a, 1);
        check("reset overflow", overflow_a, 0);
        check("reset level", level_a, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single frames from the vector table
        foreach (vecs[i]) begin
            push_a(vecs[i].data, e0);
            check("push level", level_a, 1);
            check("push empty", fifo_empty_a, 0);
            check("push busy", busy_a, 1);
            get_frame_a(r, ok);
            check("frame seen", ok, 1);
            check("frame bits", r.frame, vecs[i].frame);
            check("start latency", r.start - e0, 2);
            repeat (6) @(negedge clk);
            check("post busy", busy_a, 0);
            check("post level", level_a, 0);
            check("post empty", fifo_empty_a, 1);
            check("post tx", tx_a, 1);
        end

        // Three consecutive strobes: back-to-back frames, order kept
        push_a(8'h01, e0);
        push_a(8'h02, e1);
        push_a(8'h03, e1);
        check("b2b level", level_a, 2);
        for (int i = 0; i < 3; i++) begin
            get_frame_a(r, ok);
            check("b2b seen", ok, 1);
            check("b2b frame", r.frame, {1'b1, 8'(i + 1), 1'b0});
            starts[i] = r.start;
        end
        check("b2b latency", starts[0] - e0, 2);
        check("b2b gap 1-2", starts[1] - starts[0], 40);
        check("b2b gap 2-3", starts[2] - starts[1], 40);
        repeat (6) @(negedge clk);
        check("b2b busy end", busy_a, 0);

        // Six strobes into a depth-4 FIFO: first pops immediately, one dropped
        clr_max = 1'b1;
        @(negedge clk);
        clr_max = 1'b0;
        for (int i = 0; i < 6; i++) push_a(8'h10 + 8'(i), e0);
        check("ovf level", level_a, 4);
        check("ovf full", fifo_full_a, 1);
        check("ovf flag", overflow_a, 1);
        for (int i = 0; i < 5; i++) begin
            get_frame_a(r, ok);
            check("ovf seen", ok, 1);
            check("ovf frame", r.frame, {1'b1, 8'h10 + 8'(i), 1'b0});
            check("ovf sticky", overflow_a, 1);
        end
        repeat (60) @(negedge clk);
        check("ovf no extra frame", rxq_a.size(), 0);
        check("ovf drained busy", busy_a, 0);
        check("ovf still set", overflow_a, 1);
        check("ovf max level", max_level_a, 4);

        // Reset during DATA bit 3 of 0xF0 (bit 3 is 0, so the line is low)
        push_a(8'hF0, e0);
        while (cyc < e0 + 18) @(negedge clk);
        check("pre-reset bit3", tx_a, 0);
        rst = 1'b0;
        #1;
        check("async reset tx", tx_a, 1);
        check("async reset level", level_a, 0);
        check("async reset overflow", overflow_a, 0);
        check("async reset busy", busy_a, 0);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rxq_a.delete();
        push_a(8'h5A, e0);
        get_frame_a(r, ok);
        check("after reset seen", ok, 1);
        check("after reset frame", r.frame, 10'h2B4);
        check("after reset latency", r.start - e0, 2);
        repeat (6) @(negedge clk);

        // Fill to full, then strobe on the exact cycle the FSM pops
        push_a(8'h20, e0);
        for (int i = 1; i < 5; i++) push_a(8'h20 + 8'(i), e1);
        check("full before pop", fifo_full_a, 1);
        while (cyc < e0 + 40) @(negedge clk);
        check("full at pop-1", level_a, 4);
        push_a(8'h25, e1);
        check("pop-cycle level", level_a, 4);
        check("pop-cycle full", fifo_full_a, 1);
        check("pop-cycle overflow", overflow_a, 0);
        for (int i = 0; i < 6; i++) begin
            get_frame_a(r, ok);
            check("full seen", ok, 1);
            check("full frame", r.frame, {1'b1, 8'h20 + 8'(i), 1'b0});
        end
        repeat (60) @(negedge clk);
        check("full overflow end", overflow_a, 0);
        check("full no extra frame", rxq_a.size(), 0);

        // Random stream on the second instance, 10% strobe duty, flow-controlled
        sent = 0;
        for (t = 0; t < 30000 && sent < 200; t++) begin
            if ($urandom_range(0, 9) == 0 && !fifo_full_b) begin
                gpio_data_b = 8'($urandom);
                gpio_en_b   = 1'b1;
                exp_b.push_back(gpio_data_b);
                sent++;
            end else begin
                gpio_en_b = 1'b0;
            end
            @(negedge clk);
        end
        gpio_en_b = 1'b0;
        check("stream sent", sent, 200);
        t = 0;
        while (rxq_b.size() < sent && t < 6000) begin
            @(negedge clk);
            t++;
        end
        check("stream received", rxq_b.size(), sent);
        for (int i = 0; i < sent && i < rxq_b.size(); i++)
            check("stream frame", rxq_b[i].frame, {1'b1, exp_b[i], 1'b0});
        check("stream overflow", overflow_b, 0);
        repeat (10) @(negedge clk);
        check("stream idle", busy_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
